ddram_arbiter: RTL and testbench
================================

# ddram_arbiter

Two-port arbiter sharing the single 64-bit DDR3 burst port between the L2 cache (port 0) and a second bus master (port 1: video framebuffer fetch / DMA). It sits between the masters and the DDRAM interface. It grants the port round-robin and holds a grant for one complete transaction, meaning the read command plus all of its data beats, or every beat of a write burst. It steers read data to the owning master and stalls the other master through its BUSY input.

## Interface
- ADDRBITS, 24, DDR word-address MSB; address buses are ADDRBITS+1 bits wide.
- CLK  in  1  single clock; everything is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- Px_ADDR  in  ADDRBITS+1  64-bit word address (x = 0, 1 for every Px_ port).
- Px_DIN  in  64  write data.
- Px_BE  in  8  byte enables.
- Px_BURSTCNT  in  8  beats per transaction; 0 is treated as 1.
- Px_RD  in  1  read request; held until accepted.
- Px_WE  in  1  write beat; held until accepted.
- Px_BUSY  out  1  waitrequest back to master x.
- Px_DOUT  out  64  read data (DDRAM_DOUT broadcast to both ports).
- Px_DOUT_READY  out  1  read beat valid for master x.
- DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_BURSTCNT  out  ADDRBITS+1/64/8/8  muxed from the granted port.
- DDRAM_RD, DDRAM_WE  out  1  request from the granted port; gated by state.
- DDRAM_DOUT  in  64; DDRAM_DOUT_READY  in  1; DDRAM_BUSY  in  1.

## Operation
- Registers: state (IDLE, CMD, RD_DATA, WR_DATA), owner (1 bit), last (1 bit), beats (8 bits).
- Acceptance rule: a request is accepted when (RD|WE) & ~DDRAM_BUSY while in CMD or WR_DATA.
- IDLE:
  - req_x = Px_RD|Px_WE.
  - If only one port requests, owner takes that port.
  - If both request, owner = ~last.
  - On any request: go to CMD and set last to the new owner.
- CMD:
  - DDRAM_RD = owner RD; DDRAM_WE = owner WE. If both are asserted, RD wins and WE is masked.
  - Read accepted: beats = max(BURSTCNT,1); go to RD_DATA.
  - Write accepted with BURSTCNT ≤ 1: go to IDLE. With BURSTCNT > 1: beats = BURSTCNT-1; go to WR_DATA.
  - Owner drops both RD and WE: go to IDLE with no downstream command.
- RD_DATA:
  - DDRAM_RD = DDRAM_WE = 0.
  - Each DDRAM_DOUT_READY decrements beats.
  - When beats == 1 and a beat arrives: go to IDLE.
- WR_DATA:
  - DDRAM_WE = owner WE; DDRAM_RD = 0.
  - Each accepted beat decrements beats; at beats == 1 and acceptance: go to IDLE.
  - Address, BE and BURSTCNT pass through unchanged.
- Data return: Px_DOUT_READY = DDRAM_DOUT_READY & (state==RD_DATA) & (owner==x). Beats arriving in any other state are dropped.
- BUSY:
  - Px_BUSY = DDRAM_BUSY when owner==x and state is CMD or WR_DATA.
  - Px_BUSY = 1 in every other case, including IDLE and RD_DATA. A master therefore sees no accept before it is granted.
- Arithmetic: beats is 8-bit unsigned and never decrements below 1 while active. No wrap is possible.

## Timing
- Reset values:
  - state=IDLE, owner=0, last=1 (port 0 wins the first tie), beats=0.
  - DDRAM_RD=0, DDRAM_WE=0, P0/P1_BUSY=1, P0/P1_DOUT_READY=0.
  - DDRAM_ADDR/DIN/BE/BURSTCNT follow P0 inputs.
- Reset mid-transaction: immediate return to IDLE. Outstanding DDR read beats arriving afterwards are dropped, not forwarded.
- Arbitration latency: a request first seen in IDLE at cycle N appears on DDRAM_RD/WE in cycle N+1. It is accepted at the end of N+1 if DDRAM_BUSY=0.
- Gaps: one dead IDLE cycle between consecutive transactions. Back-to-back same-port requests still alternate under round-robin if the other port is waiting.
- Outputs in CMD/WR_DATA are combinational from the owner inputs. The only added registered stage is the grant.
- Simultaneous events:
  - A request arriving while another transaction is active waits; its BUSY stays 1.
  - A DOUT_READY in the same cycle as RD_DATA→IDLE counts toward the finishing transaction.

## Test plan
- Single P0 read, BURSTCNT=8, DDRAM_BUSY=0:
  - DDRAM_RD high exactly one cycle, one cycle after P0_RD.
  - 8 DOUT_READY beats reach P0 only; P1_DOUT_READY stays 0.
  - Return to IDLE after beat 8.
- P0 and P1 read in the same cycle from reset:
  - P0 is granted first; P1 is granted after P0's last beat plus one IDLE cycle.
  - A repeated simultaneous request then grants P1 first.
- P1 write burst BURSTCNT=4 with DDRAM_BUSY toggling 1,0,1,0…:
  - Exactly 4 beats are accepted, all with P1 data.
  - P0_RD held throughout sees P0_BUSY=1 until P1 finishes.
- DDRAM_BUSY=1 for 5 cycles in CMD:
  - The owner's BUSY mirrors DDRAM_BUSY and DDRAM_RD is held stable.
  - The command is accepted on the first cycle with DDRAM_BUSY=0.
- RESET_N pulsed low during RD_DATA after 3 of 8 beats:
  - All outputs take their reset values asynchronously.
  - The remaining 5 DDR beats produce no Px_DOUT_READY.
- BURSTCNT=0 read: treated as one beat; return to IDLE after a single DOUT_READY.

Source files
------------

// File: rtl/ddram_arbiter_if.sv
// One DDR3-style burst port: request side (addr/data/rd/we) plus wait and read-return side.
// The same bundle describes each master port and the shared downstream DDRAM port.
interface ddram_arbiter_if #(
  parameter int ADDRBITS = 24
);
  logic [ADDRBITS:0] addr;
  logic [63:0]       din;
  logic [7:0]        be;
  logic [7:0]        burstcnt;
  logic              rd;
  logic              we;
  logic              busy;
  logic [63:0]       dout;
  logic              dout_ready;

  // master issues requests; slave answers with busy and read data
  modport master (
    output addr, din, be, burstcnt, rd, we,
    input  busy, dout, dout_ready
  );

  modport slave (
    input  addr, din, be, burstcnt, rd, we,
    output busy, dout, dout_ready
  );
endinterface

// File: rtl/ddram_arbiter.sv
// Round-robin arbiter sharing one 64-bit DDR3 burst port between two masters.
// A grant is held for a whole transaction: read command plus all data beats, or every write beat.
module ddram_arbiter #(
  parameter int ADDRBITS = 24
) (
  input  logic            CLK,
  input  logic            RESET_N,
  ddram_arbiter_if.slave  p0,
  ddram_arbiter_if.slave  p1,
  ddram_arbiter_if.master ddram
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD_DATA,
    WR_DATA
  } state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_reg, last_next;
  logic [7:0]  beats_reg, beats_next;

  logic [ADDRBITS:0] own_addr;
  logic [7:0]        own_burstcnt;
  logic              own_rd;
  logic              own_we;
  logic              req0;
  logic              req1;
  logic              cmd_rd;
  logic              cmd_we;
  logic              grant_window;

  // Downstream address/data always follow the current owner, so after reset they track port 0
  assign own_addr     = owner_reg ? p1.addr : p0.addr;
  assign own_burstcnt = owner_reg ? p1.burstcnt : p0.burstcnt;
  assign own_rd       = owner_reg ? p1.rd : p0.rd;
  assign own_we       = owner_reg ? p1.we : p0.we;

  assign req0 = p0.rd | p0.we;
  assign req1 = p1.rd | p1.we;

  assign ddram.addr     = own_addr;
  assign ddram.din      = owner_reg ? p1.din : p0.din;
  assign ddram.be       = owner_reg ? p1.be : p0.be;
  assign ddram.burstcnt = own_burstcnt;
  assign ddram.rd       = cmd_rd;
  assign ddram.we       = cmd_we;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      beats_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      beats_reg <= beats_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    beats_next = beats_reg;
    cmd_rd     = 1'b0;
    cmd_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // a tie goes to the port that did not win last time
          owner_next = (req0 && req1) ? ~last_reg : req1;
          last_next  = owner_next;
          state_next = CMD;
        end
      end
      CMD: begin
        cmd_rd = own_rd;
        cmd_we = own_we & ~own_rd;
        if (!own_rd && !own_we) begin
          state_next = IDLE;
        end else if (!ddram.busy) begin
          if (own_rd) begin
            beats_next = (own_burstcnt == 8'd0) ? 8'd1 : own_burstcnt;
            state_next = RD_DATA;
          end else if (own_burstcnt <= 8'd1) begin
            state_next = IDLE;
          end else begin
            beats_next = own_burstcnt - 8'd1;
            state_next = WR_DATA;
          end
        end
      end
      RD_DATA: begin
        if (ddram.dout_ready) begin
          if (beats_reg == 8'd1) begin
            state_next = IDLE;
          end else begin
            beats_next = beats_reg - 8'd1;
          end
        end
      end
      WR_DATA: begin
        cmd_we = own_we;
        if (own_we && !ddram.busy) begin
          if (beats_reg == 8'd1) begin
            state_next = IDLE;
          end else begin
            beats_next = beats_reg - 8'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Only the owner in a command/write phase may see the downstream waitrequest
  assign grant_window = (state_reg == CMD) || (state_reg == WR_DATA);

  assign p0.busy = (grant_window && !owner_reg) ? ddram.busy : 1'b1;
  assign p1.busy = (grant_window && owner_reg) ? ddram.busy : 1'b1;

  assign p0.dout = ddram.dout;
  assign p1.dout = ddram.dout;

  assign p0.dout_ready = ddram.dout_ready && (state_reg == RD_DATA) && !owner_reg;
  assign p1.dout_ready = ddram.dout_ready && (state_reg == RD_DATA) && owner_reg;

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: cycle vector table for arbitration, then hand-written burst,
// stall and reset sequences; read/write beats are checked against a scoreboard queue.
module tb_ddram_arbiter;

  localparam int AB = 24;
  localparam logic [AB:0] P0_ADDR = 25'h0000111;
  localparam logic [AB:0] P1_ADDR = 25'h0000222;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   wr_accepts;

  ddram_arbiter_if #(.ADDRBITS(AB)) p0_bus ();
  ddram_arbiter_if #(.ADDRBITS(AB)) p1_bus ();
  ddram_arbiter_if #(.ADDRBITS(AB)) ddr_bus ();

  ddram_arbiter #(.ADDRBITS(AB)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .p0      (p0_bus.slave),
    .p1      (p1_bus.slave),
    .ddram   (ddr_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit port;
    logic [63:0] data;
  } beat_t;

  beat_t       rd_q[$];
  logic [63:0] wr_q[$];

  typedef struct {
    bit p0_rd, p1_rd, dbusy, drdy;
    bit e_rd, e_b0, e_b1, e_r0, e_r1, e_sel;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits (bounded) until the arbiter drives a downstream command; returns at a negedge
  task automatic wait_cmd(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (ddr_bus.rd || ddr_bus.we) seen = 1'b1;
      else tick();
    end
    check({name, "_grant_timeout"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic beat(input bit expect_fwd, input bit port);
    ddr_bus.dout_ready = 1'b1;
    ddr_bus.dout = {$urandom, $urandom};
    if (expect_fwd) rd_q.push_back('{port, ddr_bus.dout});
    @(negedge clk);
    tick();
    ddr_bus.dout_ready = 1'b0;
  endtask

  // scoreboard: every forwarded read beat and accepted write beat must match a queued expectation
  always @(negedge clk) begin
    beat_t e;
    logic [63:0] w;
    if (p0_bus.dout_ready || p1_bus.dout_ready) begin
      total++;
      if (rd_q.size() == 0) begin
        bad++;
        $display("FAIL rd_beat: unexpected beat p0=%b p1=%b want none", p0_bus.dout_ready, p1_bus.dout_ready);
      end else begin
        e = rd_q.pop_front();
        if ((p0_bus.dout_ready && p1_bus.dout_ready) || (p1_bus.dout_ready != e.port) ||
            ((e.port ? p1_bus.dout : p0_bus.dout) !== e.data)) begin
          bad++;
          $display("FAIL rd_beat: got port1=%b data=%h want port1=%b data=%h",
                   p1_bus.dout_ready, ddr_bus.dout, e.port, e.data);
        end
      end
    end
    if (ddr_bus.we && !ddr_bus.busy) begin
      wr_accepts++;
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_beat: unexpected write din=%h want none", ddr_bus.din);
      end else begin
        w = wr_q.pop_front();
        if (ddr_bus.din !== w || ddr_bus.addr !== P1_ADDR) begin
          bad++;
          $display("FAIL wr_beat: got din=%h addr=%h want din=%h addr=%h", ddr_bus.din, ddr_bus.addr, w, P1_ADDR);
        end
      end
    end
  end

  initial begin
    logic [63:0] wd[4];
    logic [AB:0] held_addr;
    int k;
    total = 0;
    bad = 0;
    wr_accepts = 0;

    vecs[0]  = '{1,1,0,0, 0,1,1,0,0,0};
    vecs[1]  = '{1,1,0,0, 1,0,1,0,0,0};
    vecs[2]  = '{1,1,0,1, 0,1,1,1,0,0};
    vecs[3]  = '{1,1,0,1, 0,1,1,1,0,0};
    vecs[4]  = '{1,1,0,0, 0,1,1,0,0,0};
    vecs[5]  = '{1,1,0,0, 1,1,0,0,0,1};
    vecs[6]  = '{1,1,0,1, 0,1,1,0,1,1};
    vecs[7]  = '{1,1,0,1, 0,1,1,0,1,1};
    vecs[8]  = '{1,1,0,1, 0,1,1,0,0,1};
    vecs[9]  = '{1,1,1,0, 1,1,1,0,0,0};
    vecs[10] = '{1,1,0,0, 1,0,1,0,0,0};
    vecs[11] = '{1,1,0,0, 0,1,1,0,0,0};
    vecs[12] = '{1,1,0,1, 0,1,1,1,0,0};
    vecs[13] = '{1,1,0,1, 0,1,1,1,0,0};
    vecs[14] = '{0,0,0,0, 0,1,1,0,0,0};

    rst_n = 1'b0;
    p0_bus.addr = P0_ADDR; p0_bus.din = 64'h0; p0_bus.be = 8'hff; p0_bus.burstcnt = 8'd2;
    p0_bus.rd = 1'b0; p0_bus.we = 1'b0;
    p1_bus.addr = P1_ADDR; p1_bus.din = 64'h0; p1_bus.be = 8'h0f; p1_bus.burstcnt = 8'd2;
    p1_bus.rd = 1'b0; p1_bus.we = 1'b0;
    ddr_bus.busy = 1'b0; ddr_bus.dout = 64'h0; ddr_bus.dout_ready = 1'b1;

    // reset state, with a stray DDR beat present
    @(negedge clk);
    check("rst_ddram_rd", ddr_bus.rd, 0);
    check("rst_ddram_we", ddr_bus.we, 0);
    check("rst_p0_busy", p0_bus.busy, 1);
    check("rst_p1_busy", p1_bus.busy, 1);
    check("rst_p0_rdy", p0_bus.dout_ready, 0);
    check("rst_p1_rdy", p1_bus.dout_ready, 0);
    check("rst_addr", ddr_bus.addr, P0_ADDR);
    tick();
    ddr_bus.dout_ready = 1'b0;
    rst_n = 1'b1;

    // arbitration table: tie from reset, alternation, dropped IDLE beat, CMD stall
    for (int i = 0; i < 15; i++) begin
      p0_bus.rd = vecs[i].p0_rd;
      p1_bus.rd = vecs[i].p1_rd;
      ddr_bus.busy = vecs[i].dbusy;
      ddr_bus.dout_ready = vecs[i].drdy;
      ddr_bus.dout = {$urandom, $urandom};
      if (vecs[i].e_r0 || vecs[i].e_r1) rd_q.push_back('{vecs[i].e_r1, ddr_bus.dout});
      @(negedge clk);
      $display("vec %0d: ddram_rd=%b p0_busy=%b p1_busy=%b p0_rdy=%b p1_rdy=%b",
               i, ddr_bus.rd, p0_bus.busy, p1_bus.busy, p0_bus.dout_ready, p1_bus.dout_ready);
      check($sformatf("vec%0d_rd", i), ddr_bus.rd, vecs[i].e_rd);
      check($sformatf("vec%0d_we", i), ddr_bus.we, 0);
      check($sformatf("vec%0d_b0", i), p0_bus.busy, vecs[i].e_b0);
      check($sformatf("vec%0d_b1", i), p1_bus.busy, vecs[i].e_b1);
      check($sformatf("vec%0d_r0", i), p0_bus.dout_ready, vecs[i].e_r0);
      check($sformatf("vec%0d_r1", i), p1_bus.dout_ready, vecs[i].e_r1);
      check($sformatf("vec%0d_addr", i), ddr_bus.addr, vecs[i].e_sel ? P1_ADDR : P0_ADDR);
      tick();
    end
    ddr_bus.dout_ready = 1'b0;

    // single P0 read, 8 beats: command exactly one cycle, one cycle after the request
    p0_bus.burstcnt = 8'd8;
    p0_bus.rd = 1'b1;
    @(negedge clk);
    check("a_rd_cycleN", ddr_bus.rd, 0);
    tick();
    @(negedge clk);
    check("a_rd_cycleN1", ddr_bus.rd, 1);
    check("a_p0_busy", p0_bus.busy, 0);
    tick();
    p0_bus.rd = 1'b0;
    for (int b = 0; b < 8; b++) begin
      ddr_bus.dout_ready = 1'b1;
      ddr_bus.dout = {$urandom, $urandom};
      rd_q.push_back('{1'b0, ddr_bus.dout});
      @(negedge clk);
      check("a_rd_once", ddr_bus.rd, 0);
      check("a_p1_rdy", p1_bus.dout_ready, 0);
      tick();
    end
    @(negedge clk);
    check("a_extra_beat_dropped", p0_bus.dout_ready, 0);
    check("a_idle_busy", p0_bus.busy, 1);
    tick();
    ddr_bus.dout_ready = 1'b0;
    $display("seq single_read: done");

    // P1 write burst of 4 with toggling DDRAM_BUSY while P0 holds a read request
    for (int i = 0; i < 4; i++) begin
      wd[i] = {$urandom, $urandom};
      wr_q.push_back(wd[i]);
    end
    wr_accepts = 0;
    k = 0;
    p1_bus.burstcnt = 8'd4;
    p1_bus.we = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      if (cyc == 1) begin
        p0_bus.burstcnt = 8'd0;
        p0_bus.rd = 1'b1;
      end
      ddr_bus.busy = cyc[0];
      p1_bus.din = wd[k];
      @(negedge clk);
      check("b_p0_stalled", p0_bus.busy, 1);
      if (!p1_bus.busy) k++;
      tick();
    end
    p1_bus.we = 1'b0;
    ddr_bus.busy = 1'b0;
    check("b_beats_seen", k, 4);
    check("b_beats_accepted", wr_accepts, 4);
    check("b_wr_q_empty", wr_q.size(), 0);
    $display("seq write_burst: done");

    // P0 now granted with BURSTCNT=0: exactly one beat
    wait_cmd("z");
    check("z_addr", ddr_bus.addr, P0_ADDR);
    tick();
    p0_bus.rd = 1'b0;
    beat(1'b1, 1'b0);
    ddr_bus.dout_ready = 1'b1;
    @(negedge clk);
    check("z_single_beat", p0_bus.dout_ready, 0);
    tick();
    ddr_bus.dout_ready = 1'b0;
    $display("seq burstcnt0: done");

    // DDRAM_BUSY held 5 cycles in CMD
    p1_bus.burstcnt = 8'd1;
    ddr_bus.busy = 1'b1;
    p1_bus.rd = 1'b1;
    wait_cmd("c");
    held_addr = ddr_bus.addr;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        @(negedge clk);
      end
      check("c_p1_busy", p1_bus.busy, 1);
      check("c_rd_held", ddr_bus.rd, 1);
      check("c_addr_held", ddr_bus.addr, held_addr);
    end
    tick();
    ddr_bus.busy = 1'b0;
    @(negedge clk);
    check("c_accept_busy", p1_bus.busy, 0);
    check("c_accept_rd", ddr_bus.rd, 1);
    tick();
    p1_bus.rd = 1'b0;
    @(negedge clk);
    check("c_rd_done", ddr_bus.rd, 0);
    tick();
    beat(1'b1, 1'b1);
    $display("seq cmd_stall: done");

    // reset in RD_DATA after 3 of 8 beats
    p0_bus.burstcnt = 8'd8;
    p0_bus.rd = 1'b1;
    wait_cmd("d");
    tick();
    p0_bus.rd = 1'b0;
    for (int b = 0; b < 3; b++) beat(1'b1, 1'b0);
    ddr_bus.dout_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("d_rst_rd", ddr_bus.rd, 0);
    check("d_rst_we", ddr_bus.we, 0);
    check("d_rst_p0_busy", p0_bus.busy, 1);
    check("d_rst_p1_busy", p1_bus.busy, 1);
    check("d_rst_p0_rdy", p0_bus.dout_ready, 0);
    check("d_rst_addr", ddr_bus.addr, P0_ADDR);
    tick();
    tick();
    rst_n = 1'b1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      check("d_late_beat_p0", p0_bus.dout_ready, 0);
      check("d_late_beat_p1", p1_bus.dout_ready, 0);
      tick();
    end
    ddr_bus.dout_ready = 1'b0;

    // after reset, a tie must again go to port 0
    p0_bus.burstcnt = 8'd1;
    p1_bus.burstcnt = 8'd1;
    p0_bus.rd = 1'b1;
    p1_bus.rd = 1'b1;
    wait_cmd("e");
    check("e_tie_after_reset", ddr_bus.addr, P0_ADDR);
    tick();
    p0_bus.rd = 1'b0;
    p1_bus.rd = 1'b0;
    beat(1'b1, 1'b0);
    $display("seq reset_midburst: done");

    tick();
    check("rd_q_empty", rd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
